// File: rtl/f5_rd_seq.sv
// F5 feature-RAM read sequencer: sweeps (row, lane), absorbs RAM latency, streams words out.
// Optional F5_STALL_CNT_EN adds stall_cnt, a saturating count of back-pressured busy cycles.
module f5_rd_seq #(
  parameter int N_ROW  = 32,
  parameter int N_LANE = 16,
  parameter int RD_LAT = 2,
  parameter int FDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  f5_raddr,
  output logic [3:0]  f5_sel,
  input  logic [15:0] f5_rdata,
  output logic [15:0] m_data,
  output logic [8:0]  m_idx,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
`ifdef F5_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [4:0] row_q, row_d;
  logic [3:0] lane_q, lane_d;
  logic [8:0] idx_q, idx_d;
  logic [4:0] raddr_q, raddr_d;
  logic [3:0] sel_q, sel_d;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] plast_q;
  logic [8:0]        pidx_q [RD_LAT];

  logic [15:0]       fdata_q [FDEPTH];
  logic [8:0]        fidx_q  [FDEPTH];
  logic [FDEPTH-1:0] flast_q;
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;

  logic       issue, last_word, credit, push, pop;
  logic [7:0] occ;

  assign last_word = (row_q == 5'(N_ROW - 1)) &&
                     (lane_q == 4'(N_LANE - 1));

  // Words in the RAM pipe already own a FIFO slot.
  always_comb begin
    occ = 8'(cnt_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + 8'(pv_q[i]);
    end
    credit = occ < 8'(FDEPTH);
  end

  assign push    = pv_q[RD_LAT-1];
  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = fdata_q[rp_q];
  assign m_idx   = fidx_q[rp_q];
  assign m_last  = m_valid & flast_q[rp_q];

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign f5_raddr = raddr_q;
  assign f5_sel   = sel_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = last_word ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (last_word) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_d   = row_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    raddr_d = raddr_q;
    sel_d   = sel_q;
    if (issue) begin
      raddr_d = row_q;
      sel_d   = lane_q;
      idx_d   = last_word ? 9'd0 : idx_q + 9'd1;
      if (lane_q == 4'(N_LANE - 1)) begin
        lane_d = 4'd0;
        row_d  = last_word ? 5'd0 : row_q + 5'd1;
      end else begin
        lane_d = lane_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      raddr_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      raddr_q <= raddr_d;
      sel_q   <= sel_d;
    end
  end

  // Tag pipe tracks each issued word until its data appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= '0;
      plast_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv_q[i]    <= pv_q[i-1];
        plast_q[i] <= plast_q[i-1];
        pidx_q[i]  <= pidx_q[i-1];
      end
      pv_q[0]    <= issue;
      plast_q[0] <= issue & last_word;
      pidx_q[0]  <= idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      flast_q <= '0;
      for (int i = 0; i < FDEPTH; i++) begin
        fdata_q[i] <= '0;
        fidx_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        fdata_q[wp_q] <= f5_rdata;
        fidx_q[wp_q]  <= pidx_q[RD_LAT-1];
        flast_q[wp_q] <= plast_q[RD_LAT-1];
        wp_q <= (wp_q == PW'(FDEPTH - 1)) ? '0 : wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= (rp_q == PW'(FDEPTH - 1)) ? '0 : rp_q + PW'(1);
      end
      if (push && !pop) cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == CW'(FDEPTH)));

`ifdef F5_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (busy && m_valid && !m_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_f5_rd_seq.sv
// Scoreboard bench for f5_rd_seq: default 32x16 instance plus a 1x1 instance.
// Expected words are queued at each start and checked at every handshake.
module tb_f5_rd_seq;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  i;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, m_ready;
  logic        busy, done, m_valid, m_last;
  logic [4:0]  f5_raddr;
  logic [3:0]  f5_sel;
  logic [15:0] f5_rdata = '0;
  logic [15:0] m_data;
  logic [8:0]  m_idx;

  logic        start1, m_ready1;
  logic        busy1, done1, m_valid1, m_last1;
  logic [4:0]  raddr1;
  logic [3:0]  sel1;
  logic [15:0] rdata1 = '0;
  logic [15:0] m_data1;
  logic [8:0]  m_idx1;

`ifdef F5_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  int   hs_cnt = 0;
  exp_t q[$];
  exp_t q1[$];
  bit   pend = 1'b0;
  bit   pend1 = 1'b0;

  always #5 clk = ~clk;

  f5_rd_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .f5_raddr(f5_raddr), .f5_sel(f5_sel), .f5_rdata(f5_rdata),
    .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
`ifdef F5_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  f5_rd_seq #(.N_ROW(1), .N_LANE(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .f5_raddr(raddr1), .f5_sel(sel1), .f5_rdata(rdata1),
    .m_data(m_data1), .m_idx(m_idx1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_last(m_last1)
`ifdef F5_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  // RAM models: one register after the address pins gives a 2-cycle latency from issue.
  always @(posedge clk) f5_rdata <= {7'd0, f5_raddr, f5_sel};
  always @(posedge clk) rdata1 <= 16'hC0DE + {7'd0, raddr1, sel1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("done_after_last", 32'(done), 32'd1);
      else if (done) chk("done_early", 32'(done), 32'd0);
      pend = 1'b0;
      if (m_valid && m_ready) begin
        exp_t e;
        hs_cnt++;
        if (q.size() == 0) begin
          chk("sb_underflow", 32'(m_idx), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("m_data", 32'(m_data), 32'(e.d));
          chk("m_idx", 32'(m_idx), 32'(e.i));
          chk("m_last", 32'(m_last), 32'(e.l));
        end
        pend = m_last;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend1 = 1'b0;
    end else begin
      if (pend1) chk("one_done_after_last", 32'(done1), 32'd1);
      else if (done1) chk("one_done_early", 32'(done1), 32'd0);
      pend1 = 1'b0;
      if (m_valid1 && m_ready1) begin
        exp_t e;
        if (q1.size() == 0) begin
          chk("one_sb_underflow", 32'(m_idx1), 32'hFFFF_FFFF);
        end else begin
          e = q1.pop_front();
          chk("one_m_data", 32'(m_data1), 32'(e.d));
          chk("one_m_idx", 32'(m_idx1), 32'(e.i));
          chk("one_m_last", 32'(m_last1), 32'(e.l));
        end
        pend1 = m_last1;
      end
    end
  end

  task automatic sb_load();
    for (int i = 0; i < 512; i++) begin
      exp_t e;
      e.d = 16'(i);
      e.i = 9'(i);
      e.l = (i == 511);
      q.push_back(e);
    end
  endtask

  task automatic kick();
    @(posedge clk);
    #1 start = 1'b1;
    sb_load();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic kick1();
    exp_t e;
    @(posedge clk);
    #1 start1 = 1'b1;
    e.d = 16'hC0DE;
    e.i = 9'd0;
    e.l = 1'b1;
    q1.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    bit ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk);
      #1 if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_done1(input int limit);
    bit ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("one_done_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    bit hit;
    rst_n    = 1'b0;
    start    = 1'b0;
    m_ready  = 1'b1;
    start1   = 1'b0;
    m_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_raddr", 32'(f5_raddr), 32'd0);
    chk("rst_sel", 32'(f5_sel), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_idx", 32'(m_idx), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-rate pass with latency probe and a start ignored mid-run.
    kick();
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c3", 32'(m_valid), 32'd1);
    chk("t1_idx_c3", 32'(m_idx), 32'd0);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1200, 1'b0);

    // Long stall right after start: credit limits issue to FDEPTH words.
    m_ready = 1'b0;
    kick();
    repeat (20) @(negedge clk);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_idx", 32'(m_idx), 32'd0);
    chk("t2_sel", 32'(f5_sel), 32'd3);
    chk("t2_raddr", 32'(f5_raddr), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(1200, 1'b0);

    // Random back-pressure.
    kick();
    wait_done(4000, 1'b1);

    // Reset in the middle of a pass.
    base = hs_cnt;
    hit  = 1'b0;
    kick();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (hs_cnt - base >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5_reached_100", 32'(hit), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_last", 32'(m_last), 32'd0);
    chk("t5_raddr", 32'(f5_raddr), 32'd0);
    chk("t5_sel", 32'(f5_sel), 32'd0);
    chk("t5_data", 32'(m_data), 32'd0);
    chk("t5_idx", 32'(m_idx), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    kick();
    wait_done(1200, 1'b0);

    // Single-word geometry, with a start that lands on done.
    kick1();
    wait_done1(20);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("one_ignored_start", 32'(busy1), 32'd0);
    end
    kick1();
    wait_done1(20);
    @(negedge clk);
    chk("one_idle", 32'(busy1), 32'd0);
    chk("one_sb_empty", 32'(q1.size()), 32'd0);

`ifdef F5_STALL_CNT_EN
    kick();
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6_valid_seen", 32'(hit), 32'd1);
    @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(1200, 1'b0);
    chk("t6_stall_7", 32'(stall_cnt), 32'd7);
    kick();
    @(negedge clk);
    chk("t6_stall_clr", 32'(stall_cnt), 32'd0);
    wait_done(1200, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
